// File: rtl/c0_cu_pkg.sv
// ---------------------------------------------------------------------------
// c0_cu_pkg
// Shared encodings for the C0 control sequencer: instruction classes,
// register-bank modes, special opcodes, the sequencer state enum and the
// bundle of control lines driven during EXEC.
// ---------------------------------------------------------------------------
package c0_cu_pkg;

  // Instruction class, byte0[7:6]
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MOV = 2'b01;
  localparam logic [1:0] CLS_JMP = 2'b10;
  localparam logic [1:0] CLS_SYS = 2'b11;

  // Register-bank mode driven on MS
  localparam logic [1:0] MS_ALU = 2'b00;
  localparam logic [1:0] MS_REG = 2'b01;
  localparam logic [1:0] MS_IMM = 2'b10;
  localparam logic [1:0] MS_MEM = 2'b11;

  // SYS opcode that stops the sequencer
  localparam logic [3:0] OP_SYS_HALT   = 4'b1111;
  // MOV always presents this opcode to the ALU (pass-through)
  localparam logic [3:0] OP_MOV_FORCED = 4'b0111;
  // MOV without immediate and with this OP sources from memory
  localparam logic [3:0] OP_MOV_LOAD   = 4'b0001;

  typedef enum logic [2:0] {
    ST_FETCH0,
    ST_FETCH1,
    ST_FETCH2,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic       step;
    logic       mem_inst;
    logic       alu_inst;
    logic       jmp_inst;
    logic [1:0] ms;
    logic       irs;
    logic [2:0] rs;
    logic [2:0] ar;
    logic [2:0] bs;
    logic [3:0] op;
    logic [7:0] imm;
  } ctrl_t;

  function automatic logic is_halt(input logic [7:0] byte0);
    return (byte0[7:6] == CLS_SYS) && (byte0[4:1] == OP_SYS_HALT);
  endfunction

  function automatic logic has_imm(input logic [7:0] byte0);
    return byte0[5];
  endfunction

endpackage

// File: rtl/cu_decode.sv
// ---------------------------------------------------------------------------
// cu_decode
// Purely combinational mapping of the three instruction bytes to the core's
// control fields. The sequencer registers these outputs into EXEC.
//
// Ports:
//   i_byte0      in  8  CLS[7:6] I[5] OP[4:1] BS[2][0]
//   i_byte1      in  8  RS[7:5] AR[4:2] BS[1:0]
//   i_byte2      in  8  immediate (only meaningful when I = 1)
//   o_step       out 1  core step enable (always 1 for a decoded instruction)
//   o_mem_inst   out 1  register write enable
//   o_alu_inst   out 1  ALU class strobe
//   o_jmp_inst   out 1  branch class strobe
//   o_ms         out 2  register-bank mode
//   o_irs        out 1  immediate as ALU B operand
//   o_rs/o_ar/o_bs out 3 register selects
//   o_op         out 4  ALU opcode / branch condition
//   o_imm        out 8  immediate, 0 when I = 0
// ---------------------------------------------------------------------------
module cu_decode
  import c0_cu_pkg::*;
(
  input  logic [7:0] i_byte0,
  input  logic [7:0] i_byte1,
  input  logic [7:0] i_byte2,
  output logic       o_step,
  output logic       o_mem_inst,
  output logic       o_alu_inst,
  output logic       o_jmp_inst,
  output logic [1:0] o_ms,
  output logic       o_irs,
  output logic [2:0] o_rs,
  output logic [2:0] o_ar,
  output logic [2:0] o_bs,
  output logic [3:0] o_op,
  output logic [7:0] o_imm
);

  logic [1:0] w_cls;
  logic       w_imm_en;
  logic [3:0] w_op;

  assign w_cls    = i_byte0[7:6];
  assign w_imm_en = i_byte0[5];
  assign w_op     = i_byte0[4:1];

  always_comb begin
    o_step     = 1'b1;
    o_mem_inst = 1'b0;
    o_alu_inst = 1'b0;
    o_jmp_inst = 1'b0;
    o_ms       = MS_ALU;
    o_irs      = 1'b0;
    o_rs       = i_byte1[7:5];
    o_ar       = i_byte1[4:2];
    o_bs       = {i_byte0[0], i_byte1[1:0]};
    o_op       = 4'b0000;
    o_imm      = w_imm_en ? i_byte2 : 8'h00;

    case (w_cls)
      CLS_ALU: begin
        o_alu_inst = 1'b1;
        o_mem_inst = 1'b1;
        o_irs      = w_imm_en;
        o_op       = w_op;
      end
      CLS_MOV: begin
        o_mem_inst = 1'b1;
        o_irs      = w_imm_en;
        o_op       = OP_MOV_FORCED;
        if (w_imm_en)
          o_ms = MS_IMM;
        else if (w_op == OP_MOV_LOAD)
          o_ms = MS_MEM;
        else
          o_ms = MS_REG;
      end
      CLS_JMP: begin
        o_jmp_inst = 1'b1;
        o_op       = w_op;
      end
      default: begin
        // SYS NOP: the core steps but nothing is written or selected.
        o_rs  = 3'd0;
        o_ar  = 3'd0;
        o_bs  = 3'd0;
        o_imm = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/cu_sequencer.sv
// ---------------------------------------------------------------------------
// cu_sequencer
// Control sequencer for the C0 core. Fetches a 2- or 3-byte instruction from
// the 4-byte slot at IP over a byte-wide req/ack port, decodes it and drives
// the core control lines plus STEP for exactly one EXEC cycle.
//
// Optional feature: define CU_FETCH_TIMEOUT_EN to add an 8-bit fetch wait
// counter; 256 consecutive unacknowledged fetch cycles raise FAULT and halt.
//
// Ports:
//   CLK         in  1   rising-edge clock
//   RST         in  1   asynchronous active-high reset
//   IP          in  8   core instruction pointer, sampled in FETCH0
//   FETCH_REQ   out 1   fetch request
//   FETCH_ADDR  out 10  {IP, k}, k = byte index within the slot
//   FETCH_ACK   in  1   FETCH_DATA valid this cycle
//   FETCH_DATA  in  8   instruction byte
//   STEP        out 1   core clock enable, EXEC only
//   MEM_INST, ALU_INST, JMP_INST out 1  class strobes
//   MS          out 2   register-bank mode
//   IRS         out 1   immediate selects ALU B operand
//   RS, AR, BS  out 3   register selects
//   OP          out 4   ALU opcode / branch condition
//   IMM         out 8   immediate
//   HALTED      out 1   sticky until reset
//   FAULT       out 1   fetch timeout (0 without CU_FETCH_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module cu_sequencer
  import c0_cu_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IP,
  output logic       FETCH_REQ,
  output logic [9:0] FETCH_ADDR,
  input  logic       FETCH_ACK,
  input  logic [7:0] FETCH_DATA,
  output logic       STEP,
  output logic       MEM_INST,
  output logic       ALU_INST,
  output logic       JMP_INST,
  output logic [1:0] MS,
  output logic       IRS,
  output logic [2:0] RS,
  output logic [2:0] AR,
  output logic [2:0] BS,
  output logic [3:0] OP,
  output logic [7:0] IMM,
  output logic       HALTED,
  output logic       FAULT
);

  state_t     r_state, w_state_next;
  logic [7:0] r_byte0, w_byte0_next;
  logic [7:0] r_byte1, w_byte1_next;
  logic [7:0] r_ip, w_ip_next;
  ctrl_t      r_ctrl, w_ctrl_next, w_dec;

  logic       w_in_fetch;
  logic       w_ack;
  logic       w_timeout;
  logic [9:0] w_fetch_addr;
  logic [7:0] w_dec_byte1;
  logic [7:0] w_dec_byte2;

  logic       w_d_step, w_d_mem, w_d_alu, w_d_jmp, w_d_irs;
  logic [1:0] w_d_ms;
  logic [2:0] w_d_rs, w_d_ar, w_d_bs;
  logic [3:0] w_d_op;
  logic [7:0] w_d_imm;

  assign w_in_fetch = (r_state == ST_FETCH0) || (r_state == ST_FETCH1) ||
                      (r_state == ST_FETCH2);
  // An ack outside a fetch state has no request behind it and is dropped.
  assign w_ack = w_in_fetch && FETCH_ACK;

  // The last byte of an instruction is decoded straight off FETCH_DATA so the
  // control word can be registered on the same edge that enters EXEC.
  assign w_dec_byte1 = (r_state == ST_FETCH1) ? FETCH_DATA : r_byte1;
  assign w_dec_byte2 = (r_state == ST_FETCH2) ? FETCH_DATA : 8'h00;

  cu_decode u_decode (
    .i_byte0    (r_byte0),
    .i_byte1    (w_dec_byte1),
    .i_byte2    (w_dec_byte2),
    .o_step     (w_d_step),
    .o_mem_inst (w_d_mem),
    .o_alu_inst (w_d_alu),
    .o_jmp_inst (w_d_jmp),
    .o_ms       (w_d_ms),
    .o_irs      (w_d_irs),
    .o_rs       (w_d_rs),
    .o_ar       (w_d_ar),
    .o_bs       (w_d_bs),
    .o_op       (w_d_op),
    .o_imm      (w_d_imm)
  );

  assign w_dec = {w_d_step, w_d_mem, w_d_alu, w_d_jmp, w_d_ms, w_d_irs,
                  w_d_rs, w_d_ar, w_d_bs, w_d_op, w_d_imm};

`ifdef CU_FETCH_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_fault;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wait_cnt <= 8'd0;
      r_fault    <= 1'b0;
    end else begin
      if (w_in_fetch && !FETCH_ACK)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      else
        r_wait_cnt <= 8'd0;
      if (w_timeout)
        r_fault <= 1'b1;
    end
  end

  // Counter at 255 plus another unacknowledged cycle = 256th wait cycle.
  assign w_timeout = w_in_fetch && !FETCH_ACK && (r_wait_cnt == 8'hFF);
  assign FAULT     = r_fault;
`else
  assign w_timeout = 1'b0;
  assign FAULT     = 1'b0;
`endif

  // State and captured instruction bytes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_FETCH0;
      r_byte0 <= 8'h00;
      r_byte1 <= 8'h00;
      r_ip    <= 8'h00;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_state_next;
      r_byte0 <= w_byte0_next;
      r_byte1 <= w_byte1_next;
      r_ip    <= w_ip_next;
      r_ctrl  <= w_ctrl_next;
    end
  end

  // Next state; the control word is nonzero only for the cycle entering EXEC.
  always_comb begin
    w_state_next = r_state;
    w_byte0_next = r_byte0;
    w_byte1_next = r_byte1;
    w_ip_next    = r_ip;
    w_ctrl_next  = '0;

    case (r_state)
      ST_FETCH0: begin
        if (w_ack) begin
          w_byte0_next = FETCH_DATA;
          w_ip_next    = IP;
          w_state_next = ST_FETCH1;
        end
      end
      ST_FETCH1: begin
        if (w_ack) begin
          w_byte1_next = FETCH_DATA;
          if (is_halt(r_byte0)) begin
            w_state_next = ST_HALT;
          end else if (has_imm(r_byte0)) begin
            w_state_next = ST_FETCH2;
          end else begin
            w_state_next = ST_EXEC;
            w_ctrl_next  = w_dec;
          end
        end
      end
      ST_FETCH2: begin
        if (w_ack) begin
          w_state_next = ST_EXEC;
          w_ctrl_next  = w_dec;
        end
      end
      ST_EXEC:  w_state_next = ST_FETCH0;
      ST_HALT:  w_state_next = ST_HALT;
      default:  w_state_next = ST_FETCH0;
    endcase

    if (w_timeout) begin
      w_state_next = ST_HALT;
      w_ctrl_next  = '0;
    end
  end

  // FETCH0 presents the live IP; later bytes use the IP captured with byte0,
  // which keeps the address stable even though the core may move IP.
  always_comb begin
    w_fetch_addr = 10'd0;
    case (r_state)
      ST_FETCH0: w_fetch_addr = {IP, 2'b00};
      ST_FETCH1: w_fetch_addr = {r_ip, 2'b01};
      ST_FETCH2: w_fetch_addr = {r_ip, 2'b10};
      default:   w_fetch_addr = 10'd0;
    endcase
  end

  // Gating with RST keeps the combinational fetch outputs at 0 while reset
  // is held, matching the asynchronously cleared registered outputs.
  assign FETCH_REQ  = w_in_fetch && !RST;
  assign FETCH_ADDR = RST ? 10'd0 : w_fetch_addr;

  assign STEP     = r_ctrl.step;
  assign MEM_INST = r_ctrl.mem_inst;
  assign ALU_INST = r_ctrl.alu_inst;
  assign JMP_INST = r_ctrl.jmp_inst;
  assign MS       = r_ctrl.ms;
  assign IRS      = r_ctrl.irs;
  assign RS       = r_ctrl.rs;
  assign AR       = r_ctrl.ar;
  assign BS       = r_ctrl.bs;
  assign OP       = r_ctrl.op;
  assign IMM      = r_ctrl.imm;
  assign HALTED   = (r_state == ST_HALT);

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Control sequencer for the C0 core: fetches variable-length instructions from instruction memory over a byte-wide request/acknowledge port. Decodes each instruction into the core's control lines: instruction-class strobes, register-bank mode, register selects, ALU/branch opcode and immediate. It drives those lines for exactly one EXEC cycle per instruction, together with a `STEP` enable for the core. It replaces the hand-driven control stimulus and sits between instruction memory and `core`.

## Interface
- No parameters; widths are fixed by the core: 8-bit data, 8-bit instruction pointer.
- One clock; reset is asynchronous and active-high. Clock port `CLK`, reset port `RST`.
- `CLK` in 1 — single clock, rising edge.
- `RST` in 1 — asynchronous, active-high.
- `IP` in 8 — core instruction pointer (core `Addr`).
- `FETCH_REQ` out 1 — fetch request.
- `FETCH_ADDR` out 10 — byte address `{IP, k[1:0]}`; instruction slot is 4 bytes, k = 0..2.
- `FETCH_ACK` in 1 — memory has `FETCH_DATA` valid this cycle.
- `FETCH_DATA` in 8 — instruction byte.
- `STEP` out 1 — core clock enable, high only in EXEC.
- `MEM_INST`, `ALU_INST`, `JMP_INST` out 1 each — class strobes. `MEM_INST` is the register write enable.
- `MS` out 2 — register-bank mode: 00 ALU, 01 REG, 10 IMM, 11 MEM.
- `IRS` out 1 — selects the immediate as ALU B operand.
- `RS`, `AR`, `BS` out 3 each — destination register, A/source register, B register.
- `OP` out 4 — ALU opcode or branch condition.
- `IMM` out 8 — immediate value.
- `HALTED` out 1 — sticky; cleared only by reset.
- `FAULT` out 1 — fetch timeout; tied 0 without the macro.

## Operation
- Encoding, byte0:
  - [7:6] CLS: 00 ALU, 01 MOV, 10 JMP, 11 SYS.
  - [5] I: immediate byte follows.
  - [4:1] OP.
  - [0] BS[2].
- Encoding, byte1: [7:5] RS, [4:2] AR, [1:0] BS[1:0].
- Encoding, byte2: IMM, present only when I = 1.
- States: FETCH0 → FETCH1 → (I ? FETCH2 : EXEC) → EXEC → FETCH0. SYS with OP = 1111 goes from FETCH1 to HALT.
- FETCH states:
  - Assert `FETCH_REQ` and hold `FETCH_ADDR` stable until `FETCH_ACK` is sampled high.
  - Capture the byte and advance on that edge.
- Decode in EXEC; all control outputs are registered.
- ALU: `ALU_INST`=1, `MEM_INST`=1, `MS`=00, `IRS`=I, `OP`=OP.
- MOV:
  - `MEM_INST`=1, `ALU_INST`=0.
  - `MS` = I ? 10 : (OP == 0001 ? 11 : 01); `IRS`=I.
  - `OP` forced to 0111.
- JMP: `JMP_INST`=1, `MEM_INST`=0, `OP`=condition, `IMM`=byte2 (0 if I = 0).
- SYS, OP ≠ 1111: NOP — `STEP`=1 with all strobes 0.
- When I = 0, `IMM` is driven 0.
- Outside EXEC, every output except `FETCH_*`, `HALTED` and `FAULT` is 0. The core therefore never writes outside EXEC.
- HALT: `FETCH_REQ`=0 and no `STEP` until `RST`.

## Timing
- Reset values: every output 0; state FETCH0. The first `FETCH_REQ` is asserted in the first cycle after `RST` deasserts.
- `RST` mid-operation:
  - Outputs clear immediately, asynchronously.
  - A partially fetched instruction is discarded.
  - Fetch restarts at `{IP, 00}`.
- Zero-wait memory (`FETCH_ACK` in the same cycle as `FETCH_REQ`): 3 cycles per instruction without an immediate, 4 with one. Each wait cycle adds 1.
- `IP` is sampled in FETCH0. The core updates `IP` on the EXEC edge, so the next FETCH0 sees the new value with no gap cycle.
- `FETCH_ACK` while `FETCH_REQ`=0 is ignored.

## Configuration
- `CU_FETCH_TIMEOUT_EN` defined:
  - An 8-bit wait counter runs while `FETCH_REQ`=1 and `FETCH_ACK`=0, and clears on ack.
  - After 256 consecutive wait cycles: `FAULT`=1 (sticky), `HALTED`=1, `FETCH_REQ` drops.
- Not defined: the block waits indefinitely, `FAULT` is constant 0, and no counter is present.

## Structure
- Package `c0_cu_pkg` holds:
  - CLS encodings.
  - MS encodings (ALU/REG/IMM/MEM).
  - SYS HALT opcode 1111.
  - MOV forced OP 0111.
  - State enum.
- Sub-module `cu_decode`: combinational mapping of byte0/byte1/byte2 to control fields. It is instantiated once and its outputs are registered into EXEC.

## Test plan
- MOV R0,#5 (bytes 0x60,0x00,0x05), zero-wait, IP=7:
  - `FETCH_ADDR` goes 0x01C, 0x01D, 0x01E.
  - 4th cycle: `STEP`=1, `MS`=10, `IRS`=1, `RS`=0, `IMM`=5, `MEM_INST`=1, `ALU_INST`=0.
- ADD R0,R0,R1 (0x00,0x01): EXEC on the 3rd cycle with `ALU_INST`=1, `MEM_INST`=1, `MS`=00, `BS`=001, `IRS`=0, `IMM`=0.
- JC #63 (0xB0,0x00,0x3F): `JMP_INST`=1, `MEM_INST`=0, `OP`=1000, `IMM`=63.
- HALT (0xDE,0x00):
  - `HALTED`=1, `STEP` never asserted, `FETCH_REQ` held 0 for 20 cycles.
  - `RST` pulse clears `HALTED` and fetching resumes.
- `FETCH_ACK` delayed 3 cycles on byte1, then `RST` asserted mid-FETCH1:
  - `FETCH_ADDR` stable during the wait.
  - All outputs 0 in the reset cycle; next fetch at `{IP,00}`.
- With `CU_FETCH_TIMEOUT_EN`, `FETCH_ACK` held 0: `FAULT`=1 and `HALTED`=1 after 256 wait cycles, and `FETCH_REQ` drops.
